// File: rtl/accel_tilt_ticker.sv
// Two-axis tilt ticker: signed accel samples -> thermometer tilt levels and rate-scaled move pulses.
// Optional macro TICKER_FIRST_PULSE_EN: pulse immediately on IDLE->RUN and on a sign flip in RUN.
module accel_tilt_ticker #(
  parameter int unsigned DATA_W      = 9,
  parameter int unsigned NUM_LEVELS  = 4,
  parameter int unsigned BASE_THRESH = 16,
  parameter int unsigned THRESH_STEP = 16,
  parameter int unsigned HYST        = 4,
  parameter int unsigned TICK_DIV    = 100000,
  parameter int unsigned MAX_PERIOD  = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [DATA_W-1:0]     accel_x_in,
  input  logic signed [DATA_W-1:0]     accel_y_in,
  input  logic        [15:0]           settings,
  output logic        [NUM_LEVELS-1:0] x_thresh_level,
  output logic        [NUM_LEVELS-1:0] y_thresh_level,
  output logic        [3:0]            move_pulses
);

  localparam int unsigned MAG_W = DATA_W - 1;
  localparam int unsigned THR_W = DATA_W + 3;
  localparam int unsigned LVL_W = $clog2(NUM_LEVELS + 1);
  localparam int unsigned CNT_W = $clog2(MAX_PERIOD + 1);
  localparam int unsigned DIV_W = $clog2(TICK_DIV + 1);

`ifdef TICKER_FIRST_PULSE_EN
  localparam logic FIRST_PULSE = 1'b1;
`else
  localparam logic FIRST_PULSE = 1'b0;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  logic [DIV_W-1:0]         div_q, div_d;
  logic                     tick_c;
  logic signed [DATA_W-1:0] samp_q [2];
  logic signed [DATA_W-1:0] samp_d [2];
  logic                     upd_q, upd_d;
  state_t                   state_q [2];
  state_t                   state_d [2];
  logic [LVL_W-1:0]         lvl_q [2];
  logic [LVL_W-1:0]         lvl_d [2];
  logic [CNT_W-1:0]         cnt_q [2];
  logic [CNT_W-1:0]         cnt_d [2];
  logic                     dir_q [2];
  logic                     dir_d [2];
  logic [NUM_LEVELS-1:0]    therm_x_q, therm_x_d, therm_y_q, therm_y_d;
  logic [3:0]               pulses_q, pulses_d;

  logic signed [DATA_W-1:0] val_c [2];
  logic                     neg_c [2];
  logic [MAG_W-1:0]         mag_c [2];
  logic [LVL_W-1:0]         nl_c  [2];
  logic [CNT_W-1:0]         per_c [2];
  logic [1:0]               fire_c;
  logic [CNT_W:0]           cnt_inc_c;
  logic                     unused_settings;

  assign unused_settings = ^settings[15:4];

  // Negation that maps the most-negative code onto the most-positive one.
  function automatic logic signed [DATA_W-1:0] sat_neg(input logic signed [DATA_W-1:0] v);
    if (v == {1'b1, {(DATA_W-1){1'b0}}}) return {1'b0, {(DATA_W-1){1'b1}}};
    return -v;
  endfunction

  function automatic logic [MAG_W-1:0] mag_of(input logic signed [DATA_W-1:0] v);
    logic signed [DATA_W-1:0] n;
    n = sat_neg(v);
    if (v[DATA_W-1]) return n[MAG_W-1:0];
    return v[MAG_W-1:0];
  endfunction

  function automatic logic [THR_W-1:0] thresh(input int unsigned k, input logic [1:0] s);
    logic [THR_W-1:0] t;
    t = THR_W'(BASE_THRESH + (k - 1) * THRESH_STEP) >> s;
    if (t == '0) t = THR_W'(1);
    return t;
  endfunction

  // New level: rise immediately, hold within hysteresis, otherwise fall to the raw count.
  function automatic logic [LVL_W-1:0] next_level(input logic [MAG_W-1:0] mag,
                                                 input logic [LVL_W-1:0] cur,
                                                 input logic [1:0]       s);
    logic [LVL_W-1:0] up;
    logic [THR_W-1:0] mag_e;
    up    = '0;
    mag_e = THR_W'(mag);
    for (int unsigned k = 1; k <= NUM_LEVELS; k++) begin
      if (mag_e >= thresh(k, s)) up = up + LVL_W'(1);
    end
    if (up > cur) return up;
    if (cur != '0 && (mag_e + THR_W'(HYST)) >= thresh(32'(cur), s)) return cur;
    return up;
  endfunction

  function automatic logic [CNT_W-1:0] period_of(input logic [LVL_W-1:0] lvl);
    int unsigned p;
    if (lvl == '0) p = MAX_PERIOD;
    else           p = MAX_PERIOD >> (32'(lvl) - 32'd1);
    if (p == 0) p = 1;
    return CNT_W'(p);
  endfunction

  function automatic logic [NUM_LEVELS-1:0] therm(input logic [LVL_W-1:0] lvl);
    logic [NUM_LEVELS-1:0] t;
    for (int unsigned k = 0; k < NUM_LEVELS; k++) t[k] = (32'(lvl) > k);
    return t;
  endfunction

  // Tick divider and sample capture.
  always_comb begin
    tick_c = (div_q == DIV_W'(TICK_DIV - 1));
    div_d  = tick_c ? '0 : div_q + DIV_W'(1);
    upd_d  = tick_c;
    samp_d[0] = tick_c ? accel_x_in : samp_q[0];
    samp_d[1] = tick_c ? accel_y_in : samp_q[1];
  end

  // Per-axis inversion, magnitude, level and period for the pending update.
  always_comb begin
    for (int a = 0; a < 2; a++) begin
      val_c[a] = settings[2+a] ? sat_neg(samp_q[a]) : samp_q[a];
      neg_c[a] = val_c[a][DATA_W-1];
      mag_c[a] = mag_of(val_c[a]);
      nl_c[a]  = next_level(mag_c[a], lvl_q[a], settings[1:0]);
      per_c[a] = period_of(nl_c[a]);
    end
  end

  // Pulse FSM next-state and outputs.
  always_comb begin
    state_d   = state_q;
    lvl_d     = lvl_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    therm_x_d = therm_x_q;
    therm_y_d = therm_y_q;
    pulses_d  = '0;
    fire_c    = '0;
    cnt_inc_c = '0;
    if (upd_q) begin
      for (int a = 0; a < 2; a++) begin
        cnt_inc_c = (CNT_W+1)'(cnt_q[a]) + (CNT_W+1)'(1);
        case (state_q[a])
          IDLE: begin
            if (nl_c[a] != '0) begin
              state_d[a] = RUN;
              cnt_d[a]   = '0;
              fire_c[a]  = FIRST_PULSE;
            end
          end
          RUN: begin
            if (nl_c[a] == '0) begin
              state_d[a] = IDLE;
              cnt_d[a]   = '0;
            end else if (neg_c[a] != dir_q[a]) begin
              cnt_d[a]  = '0;
              fire_c[a] = FIRST_PULSE;
            end else if (cnt_inc_c >= (CNT_W+1)'(per_c[a])) begin
              cnt_d[a]  = '0;
              fire_c[a] = 1'b1;
            end else begin
              cnt_d[a] = cnt_q[a] + CNT_W'(1);
            end
          end
          default: state_d[a] = IDLE;
        endcase
        lvl_d[a]        = nl_c[a];
        dir_d[a]        = neg_c[a];
        pulses_d[2*a]   = fire_c[a] & ~neg_c[a];
        pulses_d[2*a+1] = fire_c[a] & neg_c[a];
      end
      therm_x_d = therm(nl_c[0]);
      therm_y_d = therm(nl_c[1]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q     <= '0;
      upd_q     <= 1'b0;
      therm_x_q <= '0;
      therm_y_q <= '0;
      pulses_q  <= '0;
      for (int a = 0; a < 2; a++) begin
        samp_q[a]  <= '0;
        state_q[a] <= IDLE;
        lvl_q[a]   <= '0;
        cnt_q[a]   <= '0;
        dir_q[a]   <= 1'b0;
      end
    end else begin
      div_q     <= div_d;
      upd_q     <= upd_d;
      therm_x_q <= therm_x_d;
      therm_y_q <= therm_y_d;
      pulses_q  <= pulses_d;
      for (int a = 0; a < 2; a++) begin
        samp_q[a]  <= samp_d[a];
        state_q[a] <= state_d[a];
        lvl_q[a]   <= lvl_d[a];
        cnt_q[a]   <= cnt_d[a];
        dir_q[a]   <= dir_d[a];
      end
    end
  end

  assign x_thresh_level = therm_x_q;
  assign y_thresh_level = therm_y_q;
  assign move_pulses    = pulses_q;

endmodule

// File: tb/tb_accel_tilt_ticker.sv
// Bench for accel_tilt_ticker: table of tilt segments, tick-level scoreboard, hand-timed corner sequences.
module tb_accel_tilt_ticker;

`ifdef TICKER_FIRST_PULSE_EN
  localparam int FP = 1;
`else
  localparam int FP = 0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic signed [7:0] ax, ay;
  logic [15:0]       settings;
  logic [3:0]        xl, yl, mp;

  always #5 clk = ~clk;

  accel_tilt_ticker #(.DATA_W(8), .TICK_DIV(4)) dut (
    .clk(clk), .reset(reset), .accel_x_in(ax), .accel_y_in(ay), .settings(settings),
    .x_thresh_level(xl), .y_thresh_level(yl), .move_pulses(mp)
  );

  typedef struct { int x; int y; int set; int ticks; logic [3:0] exl; logic [3:0] eyl; } vec_t;
  typedef struct { logic [3:0] xl; logic [3:0] yl; logic [3:0] mp; } exp_t;

  vec_t vecs [12];
  exp_t sb [$];
  int   lpxp [$], lpxn [$], lpyp [$], lpyn [$], lboth [$];
  int   n_checks = 0, n_pass = 0, tick_rel = 0;
  int   m_lvl [2], m_dir [2], m_run [2], m_cnt [2];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int thr(input int k, input int s);
    int t;
    t = (16 + (k - 1) * 16) >> s;
    return (t == 0) ? 1 : t;
  endfunction

  function automatic int period(input int l);
    int p;
    p = 64 >> (l - 1);
    return (p < 1) ? 1 : p;
  endfunction

  function automatic logic [3:0] therm(input int l);
    return 4'((1 << l) - 1);
  endfunction

  function automatic int first_of(input int q [$]);
    return (q.size() > 0) ? q[0] : -1;
  endfunction

  task automatic model_reset();
    for (int a = 0; a < 2; a++) begin
      m_lvl[a] = 0; m_dir[a] = 0; m_run[a] = 0; m_cnt[a] = 0;
    end
  endtask

  // One tick of the reference behaviour for one axis.
  task automatic model_axis(input int a, input int raw, input bit inv, input int s,
                            output bit fire, output bit neg);
    int v, mag, up, nl;
    v = raw;
    if (inv) v = (v == -128) ? 127 : -v;
    neg = (v < 0);
    mag = (v == -128) ? 127 : ((v < 0) ? -v : v);
    up = 0;
    for (int k = 1; k <= 4; k++) if (mag >= thr(k, s)) up++;
    if (up > m_lvl[a]) nl = up;
    else if (m_lvl[a] > 0 && mag + 4 >= thr(m_lvl[a], s)) nl = m_lvl[a];
    else nl = up;
    fire = 1'b0;
    if (m_run[a] == 0) begin
      if (nl > 0) begin m_run[a] = 1; m_cnt[a] = 0; fire = bit'(FP); end
    end else if (nl == 0) begin
      m_run[a] = 0; m_cnt[a] = 0;
    end else if (int'(neg) != m_dir[a]) begin
      m_cnt[a] = 0; fire = bit'(FP);
    end else begin
      m_cnt[a]++;
      if (m_cnt[a] >= period(nl)) begin fire = 1'b1; m_cnt[a] = 0; end
    end
    m_lvl[a] = nl;
    m_dir[a] = int'(neg);
  endtask

  task automatic clear_logs();
    lpxp.delete(); lpxn.delete(); lpyp.delete(); lpyn.delete(); lboth.delete();
    tick_rel = 0;
  endtask

  // Drive one tick's inputs, push the expectation, then compare at the update clk.
  task automatic run_tick(input int x, input int y, input int set);
    exp_t e;
    bit fx, nx, fy, ny;
    ax = 8'(x); ay = 8'(y); settings = 16'(set);
    model_axis(0, x, bit'((set >> 2) & 1), set & 3, fx, nx);
    model_axis(1, y, bit'((set >> 3) & 1), set & 3, fy, ny);
    e.xl = therm(m_lvl[0]);
    e.yl = therm(m_lvl[1]);
    e.mp = {fy & ny, fy & ~ny, fx & nx, fx & ~nx};
    sb.push_back(e);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("pulse_between_ticks", int'(mp), 0);
    end
    @(posedge clk); #1;
    e = sb.pop_front();
    check("tick_x_level", int'(xl), int'(e.xl));
    check("tick_y_level", int'(yl), int'(e.yl));
    check("tick_pulses", int'(mp), int'(e.mp));
    if (mp[0]) lpxp.push_back(tick_rel);
    if (mp[1]) lpxn.push_back(tick_rel);
    if (mp[2]) lpyp.push_back(tick_rel);
    if (mp[3]) lpyn.push_back(tick_rel);
    if (mp == 4'b0101) lboth.push_back(tick_rel);
    tick_rel++;
  endtask

  task automatic do_release();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(posedge clk); #1;
    check("first_clk_after_release", int'(mp), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{40,    0,  0, 70, 4'b0011, 4'b0000};
    vecs[1]  = '{30,    0,  0,  5, 4'b0011, 4'b0000};
    vecs[2]  = '{27,    0,  0,  5, 4'b0001, 4'b0000};
    vecs[3]  = '{-5,    0,  0,  3, 4'b0000, 4'b0000};
    vecs[4]  = '{0,  -128,  2, 20, 4'b0000, 4'b1111};
    vecs[5]  = '{0,  -128, 10, 20, 4'b0000, 4'b1111};
    vecs[6]  = '{0,     0,  0,  2, 4'b0000, 4'b0000};
    vecs[7]  = '{70,   70,  0, 20, 4'b1111, 4'b1111};
    vecs[8]  = '{-70,  70,  0, 20, 4'b1111, 4'b1111};
    vecs[9]  = '{2,    -8,  3, 10, 4'b0001, 4'b1111};
    vecs[10] = '{-128, -8,  4, 10, 4'b1111, 4'b0000};
    vecs[11] = '{127,   0,  4, 10, 4'b1111, 4'b0000};

    // Held in reset with a large tilt: everything stays quiet.
    reset = 1'b0; ax = 8'sd100; ay = 8'sd0; settings = 16'h0;
    repeat (6) @(posedge clk);
    #1;
    check("reset_hold_x_level", int'(xl), 0);
    check("reset_hold_y_level", int'(yl), 0);
    check("reset_hold_pulses",  int'(mp), 0);

    do_release();
    for (int i = 0; i < 12; i++) begin
      clear_logs();
      for (int t = 0; t < vecs[i].ticks; t++) run_tick(vecs[i].x, vecs[i].y, vecs[i].set);
      check($sformatf("seg%0d_x_level", i), int'(xl), int'(vecs[i].exl));
      check($sformatf("seg%0d_y_level", i), int'(yl), int'(vecs[i].eyl));
      case (i)
        0: begin
          check("lvl2_pos_x_pulse_count", lpxp.size(), 2 + FP);
          check("lvl2_first_pos_x_tick", first_of(lpxp), (FP != 0) ? 0 : 32);
          check("lvl2_neg_x_count", lpxn.size(), 0);
        end
        5: begin
          check("inv_y_first_pos_y_tick", first_of(lpyp), (FP != 0) ? 0 : 8);
          check("inv_y_neg_y_count", lpyn.size(), 0);
        end
        7: begin
          check("sync_xy_pulse_count", lboth.size(), 2 + FP);
          check("sync_xy_first_tick", first_of(lboth), (FP != 0) ? 0 : 8);
        end
        8: begin
          check("flip_first_neg_x_tick", first_of(lpxn), (FP != 0) ? 0 : 8);
          check("flip_pos_x_count", lpxp.size(), 0);
        end
        default: ;
      endcase
    end

    // Asynchronous reset away from any clock edge.
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_x_level", int'(xl), 0);
    check("async_reset_y_level", int'(yl), 0);
    check("async_reset_pulses",  int'(mp), 0);
    repeat (3) @(posedge clk);
    do_release();
    clear_logs();
    for (int t = 0; t < 40; t++) run_tick(40, 0, 0);
    check("restart_first_pos_x_tick", first_of(lpxp), (FP != 0) ? 0 : 32);
    check("restart_x_level", int'(xl), 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/accel_tilt_ticker.md
Name: accel_tilt_ticker

Overview:
- Parametrised successor to the two-axis accelerometer threshold ticker.
- Converts signed X/Y tilt samples into per-axis tilt levels (thermometer-coded, for the LED bar) and direction move pulses (for the ball mover).
- Adds configurable level count, sample width, selectable sensitivity, per-axis hysteresis, axis inversion and level-scaled pulse rates.
- Sits between the accelerometer controller and the ball/LED logic in the top level.

Parameters:
- DATA_W, 9: accel sample width, two's complement.
- NUM_LEVELS, 4: number of tilt thresholds per axis (1..8).
- BASE_THRESH, 16: magnitude of level-1 threshold at sensitivity 0.
- THRESH_STEP, 16: magnitude increment per level.
- HYST, 4: downward hysteresis, in magnitude counts.
- TICK_DIV, 100000: clk cycles per tick (1 kHz at 100 MHz).
- MAX_PERIOD, 64: ticks between pulses at level 1.

Ports:
- clk  in  1: system clock.
- reset  in  1: asynchronous, active-low reset.
- accel_x_in  in  DATA_W: signed X sample.
- accel_y_in  in  DATA_W: signed Y sample.
- settings  in  16: [1:0] sensitivity shift s; [2] invert X; [3] invert Y; [15:4] ignored.
- x_thresh_level  out  NUM_LEVELS: X level, thermometer code (bit k set if level > k).
- y_thresh_level  out  NUM_LEVELS: Y level, thermometer code.
- move_pulses  out  4: one-clk pulses; [0]=+X, [1]=-X, [2]=+Y, [3]=-Y.

Behaviour:
- Reset (async, reset=0): tick divider, levels, period counters, direction registers and move_pulses all 0. Reset asserted mid-count discards all progress; the first tick after release counts from 0.
- Tick: divider counts 0..TICK_DIV-1. tick_strobe is high for one clk when the divider wraps. The first strobe occurs TICK_DIV clks after reset release.
- Sampling: on tick_strobe, register accel_x_in and accel_y_in, then apply inversion from settings. Outputs change only in the clk after a strobe (latency 1 clk from strobe).
- Inversion: negating the most-negative code saturates to the maximum positive value.
- Magnitude: abs value, width DATA_W-1. The most-negative code saturates to 2^(DATA_W-1)-1. Sign register holds 1 for negative.
- Threshold k (k=1..NUM_LEVELS) = (BASE_THRESH + (k-1)*THRESH_STEP) >> s. Compute in DATA_W+3 bits; any threshold that is 0 after the shift is treated as 1.
- Level update per axis, each tick (cur = current level, 0..NUM_LEVELS):
  - up = count of k with mag >= thresh_k.
  - If up > cur, level = up.
  - Else if cur > 0 and mag + HYST >= thresh_cur, level = cur (hold).
  - Else level = up; this may drop several levels in one tick.
- Direction: captured each tick from the sign register. The direction for a zero magnitude is +.
- Pulse state machine per axis, states IDLE and RUN:
  - IDLE: level 0; counter held at 0; no pulses.
  - IDLE -> RUN: level becomes >0; counter cleared.
  - RUN: counter increments per tick. When counter+1 == period(level), assert the direction pulse for exactly one clk (same clk as the level/counter update) and clear the counter.
  - period(L) = max(1, MAX_PERIOD >> (L-1)).
  - RUN -> IDLE: level becomes 0; counter cleared; no pulse on that tick.
  - Sign flip while in RUN: counter cleared; no pulse on that tick; counting continues in the new direction.
  - Level change while in RUN: counter kept. If counter >= new period, pulse on that tick and clear.
- +X and -X are never high together; the same holds for +Y and -Y. X and Y are independent and may pulse in the same clk.
- Settings changes take effect at the next tick.

Optional Feature:
- Macro: TICKER_FIRST_PULSE_EN.
- Defined: the IDLE->RUN transition and a sign flip in RUN both emit one pulse immediately, on that tick, in the new direction; the counter then starts from 0.
- Undefined: the first pulse arrives after period(level) ticks, per the Behaviour section.

Test Plan:
- TICK_DIV=4 throughout.
- Reset hold: reset=0 with X=+100 -> all outputs 0. After release, first level update at clk 5 after the first strobe boundary; move_pulses stays 0 until 1 full period elapses.
- Level/rate: X=+40, s=0 -> x_thresh_level=4'b0011; move_pulses[0] pulses every 32 ticks (128 clks), width 1 clk; move_pulses[1] never pulses.
- Hysteresis: from X=+40, step to 30 -> level stays 2; step to 27 -> level 1, period 64 ticks. Step to -5 -> level 0, IDLE, no pulses.
- Sensitivity/saturation: s=2, Y=-128 -> mag 127, y_thresh_level=4'b1111, move_pulses[3] every 8 ticks. Set settings[3]=1 -> move_pulses[2] every 8 ticks after a 1-tick reset of the counter.
- Sign flip and simultaneity: X=+70, Y=+70 -> [0] and [2] pulse in the same clk every 8 ticks. Flip X to -70 mid-period -> X counter clears; first [1] pulse comes 8 ticks later (with TICKER_FIRST_PULSE_EN: on the flip tick).
- Async reset mid-RUN: drop reset between pulses -> outputs 0 within the same clk, without waiting for a clk edge. After release, counters restart from 0.
